grf_scoreboard: RTL and testbench

Parametrised general-purpose register file with N combinational read ports, one synchronous write port, optional write-to-read bypass, and a per-register pending-write scoreboard. It replaces the fixed 32×32, two-read-port register file in the pipelined MIPS core. Decode reads operands and busy status here. Issue marks destination registers pending, and writeback retires them. Register 0 is hard-wired to zero and is never pending.

---
 rtl/grf_scoreboard.sv | 82 ++++++++
 tb/tb_grf_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// Parametrised register file: N combinational read ports, one synchronous write
// port, optional write-to-read bypass and a per-register pending-write scoreboard.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    RegWr,
  input  logic [ADDR_W-1:0]       RWAddr,
  input  logic [DATA_W-1:0]       RWData,
  input  logic [NREAD*ADDR_W-1:0] RAddr,
  output logic [NREAD*DATA_W-1:0] RData,
  output logic [NREAD-1:0]        RBusy,
  input  logic                    Issue,
  input  logic [ADDR_W-1:0]       IssueAddr,
  output logic [ADDR_W:0]         BusyCnt
);

  // No valid/ready handshake: every rising edge accepts one write (RegWr) and
  // one issue (Issue); there is no back-pressure in either direction.

  localparam int   NREGS     = 1 << ADDR_W;
  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [ADDR_W:0]   cnt_next;

  logic wr_en;
  logic set_en;
  logic byp_en;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_en  = RegWr && (RWAddr != '0);
  assign set_en = Issue && (IssueAddr != '0);
  assign byp_en = BYPASS_EN && Reset_n && RegWr;

  // Read ports: register 0 reads zero, then bypass, then the stored array.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;

    assign rd_addr = RAddr[k*ADDR_W +: ADDR_W];
    assign rd_hit  = byp_en && (RWAddr == rd_addr);
    assign RData[k*DATA_W +: DATA_W] = (rd_addr == '0) ? '0 :
                                       rd_hit          ? RWData :
                                                         regs[rd_addr];
    assign RBusy[k] = busy[rd_addr] & ~rd_hit;
  end

  // Clear is applied before set so a new producer on the same address wins.
  always_comb begin
    busy_next = busy;
    if (wr_en)  busy_next[RWAddr]    = 1'b0;
    if (set_en) busy_next[IssueAddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_inc  = set_en && !busy[IssueAddr];
    cnt_dec  = wr_en && busy[RWAddr] && !(set_en && (IssueAddr == RWAddr));
    cnt_next = BusyCnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy    <= '0;
      BusyCnt <= '0;
    end else begin
      if (wr_en) regs[RWAddr] <= RWData;
      busy    <= busy_next;
      BusyCnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: one instance with bypass, one without,
// sharing the same stimulus.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        regwr;
  logic [4:0]  rwaddr;
  logic [31:0] rwdata;
  logic [9:0]  raddr;
  logic        issue;
  logic [4:0]  issueaddr;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // Clock / reset
  always #5 clk = ~clk;

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1)) u_byp (
    .clk(clk), .Reset_n(reset_n), .RegWr(regwr), .RWAddr(rwaddr), .RWData(rwdata),
    .RAddr(raddr), .RData(rdata_b), .RBusy(rbusy_b), .Issue(issue),
    .IssueAddr(issueaddr), .BusyCnt(cnt_b)
  );

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .Reset_n(reset_n), .RegWr(regwr), .RWAddr(rwaddr), .RWData(rwdata),
    .RAddr(raddr), .RData(rdata_n), .RBusy(rbusy_n), .Issue(issue),
    .IssueAddr(issueaddr), .BusyCnt(cnt_n)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    regwr = 1'b0;
    issue = 1'b0;
  endtask

  task automatic drive_wr(input logic [4:0] a, input logic [31:0] d);
    regwr  = 1'b1;
    rwaddr = a;
    rwdata = d;
  endtask

  task automatic drive_issue(input logic [4:0] a);
    issue     = 1'b1;
    issueaddr = a;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    raddr = {p1, p0};
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    regwr     = 1'b0;
    rwaddr    = '0;
    rwdata    = '0;
    issue     = 1'b0;
    issueaddr = '0;
    raddr     = '0;

    // Reset and register 0
    tick();
    set_rd(5'd5, 5'd7);
    settle();
    check("rst_rdata_b", rdata_b, 64'h0);
    check("rst_rdata_n", rdata_n, 64'h0);
    check("rst_cnt_b", cnt_b, 6'd0);
    check("rst_rbusy_b", rbusy_b, 2'b00);
    reset_n = 1'b1;
    drive_wr(5'd0, 32'hDEADBEEF);
    set_rd(5'd0, 5'd0);
    settle();
    check("r0_bypass_b", rdata_b, 64'h0);
    tick();
    idle();
    settle();
    check("r0_after_b", rdata_b, 64'h0);
    check("r0_after_n", rdata_n, 64'h0);
    check("r0_cnt_n", cnt_n, 6'd0);

    // Write then read, with and without bypass
    drive_wr(5'd5, 32'h12345678);
    set_rd(5'd5, 5'd5);
    settle();
    check("wr5_t_b", rdata_b, {2{32'h12345678}});
    check("wr5_t_n", rdata_n[31:0], 32'h0);
    tick();
    idle();
    settle();
    check("wr5_t1_b", rdata_b[31:0], 32'h12345678);
    check("wr5_t1_n", rdata_n, {2{32'h12345678}});
    check("wr5_cnt", cnt_b, 6'd0);

    // Scoreboard round trip on reg 8
    drive_issue(5'd8);
    set_rd(5'd8, 5'd8);
    settle();
    check("iss8_t_busy", rbusy_b, 2'b00);
    tick();
    idle();
    settle();
    check("iss8_busy_b", rbusy_b, 2'b11);
    check("iss8_cnt_b", cnt_b, 6'd1);
    check("iss8_cnt_n", cnt_n, 6'd1);
    tick();
    tick();
    drive_wr(5'd8, 32'hA5);
    settle();
    check("wb8_busy_b", rbusy_b, 2'b00);
    check("wb8_busy_n", rbusy_n, 2'b11);
    check("wb8_data_b", rdata_b[31:0], 32'hA5);
    tick();
    idle();
    settle();
    check("wb8_cnt_b", cnt_b, 6'd0);
    check("wb8_busy_n_t1", rbusy_n, 2'b00);
    check("wb8_data_n", rdata_n[63:32], 32'hA5);

    // Simultaneous set and clear
    drive_issue(5'd3);
    tick();
    idle();
    drive_issue(5'd3);
    drive_wr(5'd3, 32'h77);
    tick();
    idle();
    set_rd(5'd3, 5'd0);
    settle();
    check("sc3_data_n", rdata_n[31:0], 32'h77);
    check("sc3_busy_b", rbusy_b, 2'b01);
    check("sc3_cnt_b", cnt_b, 6'd1);
    drive_issue(5'd4);
    drive_wr(5'd3, 32'h88);
    tick();
    idle();
    set_rd(5'd3, 5'd4);
    settle();
    check("sc4_busy_b", rbusy_b, 2'b10);
    check("sc4_busy_n", rbusy_n, 2'b10);
    check("sc4_cnt_b", cnt_b, 6'd1);
    check("sc4_data_n", rdata_n[31:0], 32'h88);
    drive_wr(5'd4, 32'h44);
    tick();
    idle();
    settle();
    check("clr4_cnt", cnt_n, 6'd0);

    // Issue to reg 0, double issue of reg 9
    drive_issue(5'd0);
    tick();
    drive_issue(5'd9);
    tick();
    tick();
    idle();
    set_rd(5'd0, 5'd9);
    settle();
    check("dbl9_cnt_b", cnt_b, 6'd1);
    check("dbl9_busy_b", rbusy_b, 2'b10);

    // Readback of a small block through port 1
    for (int i = 0; i < 4; i++) begin
      drive_wr(5'(10 + i), 32'h1000_0000 + 32'(i) * 32'h0101);
      exp_q.push_back(32'h1000_0000 + 32'(i) * 32'h0101);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_rd(5'd0, 5'(10 + i));
      settle();
      exp_v = exp_q.pop_front();
      check("blk_rd_b", rdata_b[63:32], exp_v);
      check("blk_rd_n", rdata_n[63:32], exp_v);
    end

    // Full scoreboard then reset mid-operation
    drive_wr(5'd1, 32'h1111);
    tick();
    idle();
    for (int i = 1; i < 32; i++) begin
      drive_issue(5'(i));
      tick();
    end
    idle();
    set_rd(5'd1, 5'd31);
    settle();
    check("full_cnt_b", cnt_b, 6'd31);
    check("full_cnt_n", cnt_n, 6'd31);
    check("full_busy_n", rbusy_n, 2'b11);
    reset_n = 1'b0;
    drive_wr(5'd1, 32'hCAFE);
    settle();
    check("rstw_nobyp_b", rdata_b[31:0], 32'h1111);
    tick();
    reset_n = 1'b1;
    idle();
    settle();
    check("rstm_cnt_b", cnt_b, 6'd0);
    check("rstm_cnt_n", cnt_n, 6'd0);
    check("rstm_busy_b", rbusy_b, 2'b00);
    check("rstm_r1_b", rdata_b[31:0], 32'h0);
    check("rstm_r1_n", rdata_n[31:0], 32'h0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
